exec_ctrl: RTL

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_if.sv | 29 ++
 rtl/exec_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: request/response, register-control and ALU bus between a host and exec_ctrl.
interface exec_ctrl_if;
    logic       start;
    logic [7:0] instr;
    logic       ready;
    logic [3:0] acc_q;
    logic [3:0] alu_f;
    logic [2:0] alu_oc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
    logic [3:0] reg_in;
    logic       done;
    logic [3:0] result;

    modport master (
        output start, instr, acc_q, alu_f,
        input  ready, alu_oc, alu_a, alu_b,
        input  reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
        input  reg_in, done, result
    );

    modport slave (
        input  start, instr, acc_q, alu_f,
        output ready, alu_oc, alu_a, alu_b,
        output reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
        output reg_in, done, result
    );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle instruction sequencer driving an external 4-bit register and ALU.
// Define EXEC_CTRL_ROT_EN to make op 7 a rotate-right; otherwise op 7 behaves as NOP.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    exec_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, ALU, WB, SHIFT, DONE} state_t;

    state_t     r_state, w_next;
    logic [3:0] r_op, r_imm, r_cnt, r_hold, r_result;
    logic       w_rot_en, w_shift_op, w_simple_op;

`ifdef EXEC_CTRL_ROT_EN
    assign w_rot_en = 1'b1;
`else
    assign w_rot_en = 1'b0;
`endif

    assign w_shift_op  = (r_op == 4'd5) || (r_op == 4'd6) || (r_op == 4'd7 && w_rot_en);
    assign w_simple_op = (r_op >= 4'd1) && (r_op <= 4'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? DECODE : IDLE;
            DECODE:  w_next = r_op[3] ? ALU : w_simple_op ? EXEC :
                              (w_shift_op && r_imm != 4'd0) ? SHIFT : DONE;
            EXEC:    w_next = DONE;
            ALU:     w_next = WB;
            WB:      w_next = DONE;
            SHIFT:   w_next = (r_cnt == 4'd1) ? DONE : SHIFT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_imm    <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_result <= '0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_op  <= bus.instr[7:4];
                r_imm <= bus.instr[3:0];
            end
            if (r_state == DECODE)     r_cnt <= r_imm;
            else if (r_state == SHIFT) r_cnt <= r_cnt - 4'd1;
            if (r_state == ALU)  r_hold   <= bus.alu_f;
            if (r_state == DONE) r_result <= bus.acc_q;
        end
    end

    assign bus.ready   = (r_state == IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.result  = bus.done ? bus.acc_q : r_result;
    assign bus.reg_cl  = (r_state == EXEC) && (r_op == 4'd1);
    assign bus.reg_ld  = ((r_state == EXEC) && (r_op == 4'd2)) || (r_state == WB);
    assign bus.reg_inc = (r_state == EXEC) && (r_op == 4'd3);
    assign bus.reg_dec = (r_state == EXEC) && (r_op == 4'd4);
    assign bus.reg_sr  = (r_state == SHIFT) && (r_op == 4'd5 || r_op == 4'd7);
    // Rotate feeds the bit shifted out back in at the top.
    assign bus.reg_ir  = (r_state == SHIFT) && (r_op == 4'd7) && w_rot_en && bus.acc_q[0];
    assign bus.reg_sl  = (r_state == SHIFT) && (r_op == 4'd6);
    assign bus.reg_il  = 1'b0;
    assign bus.reg_in  = (r_state == WB) ? r_hold :
                         ((r_state == EXEC) && (r_op == 4'd2)) ? r_imm : 4'd0;
    assign bus.alu_oc  = (r_state == ALU) ? r_op[2:0] : 3'd0;
    assign bus.alu_a   = (r_state == ALU) ? bus.acc_q : 4'd0;
    assign bus.alu_b   = (r_state == ALU) ? r_imm : 4'd0;
endmodule
